// File: rtl/fall_feature_extractor.sv
// Windowed mean / std-deviation feature extractor feeding the fall-detection SVM.
// Accumulates 2^WINDOW_LOG2 Q8.8 samples, then emits Q16.16 mean and std with a one-cycle start.
module fall_feature_extractor #(
  parameter int WINDOW_LOG2 = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_in,
  output logic [31:0] feature_mean,
  output logic [31:0] feature_std,
  output logic        start
);

  // state | meaning
  // ACC   | accepting samples into sum / sumsq
  // CALC  | mean and clamped variance, load sqrt radicand
  // SQRT  | 24 restoring square-root iterations, MSB first
  // EMIT  | publish features, pulse start, clear accumulators
  typedef enum logic [1:0] {ACC, CALC, SQRT, EMIT} state_t;

  localparam int SUM_W = 16 + WINDOW_LOG2;
  localparam int SQ_W  = 32 + WINDOW_LOG2;

  state_t                  state_q, state_d;
  logic [WINDOW_LOG2-1:0]  count_q, count_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [SQ_W-1:0]         sumsq_q, sumsq_d;
  logic signed [15:0]      mean_q, mean_d;
  logic [47:0]             rad_q, rad_d;
  logic [25:0]             rem_q, rem_d;
  logic [23:0]             root_q, root_d;
  logic [4:0]              iter_q, iter_d;
  logic [31:0]             mean_out_q, mean_out_d;
  logic [31:0]             std_out_q, std_out_d;
  logic                    start_q, start_d;

  logic                    accept;
  logic                    last_sample;
  logic signed [15:0]      sample_s;
  logic [31:0]             prod;
  logic signed [15:0]      mean_w;
  logic [31:0]             msq_w;
  logic signed [31:0]      mean_sq_w;
  logic [32:0]             var_w;
  logic [31:0]             var_clamp;
  logic [27:0]             rem_shift;
  logic [27:0]             trial;

  assign accept      = sample_valid && sample_ready;
  assign last_sample = (count_q == '1);
  assign sample_s    = sample_in;
  assign prod        = 32'(sample_s) * 32'(sample_s);

  // floor mean and E[x^2]; a floored negative mean can push the variance below zero
  assign mean_w    = 16'(sum_q >>> WINDOW_LOG2);
  assign msq_w     = 32'(sumsq_q >> WINDOW_LOG2);
  assign mean_sq_w = 32'(mean_w) * 32'(mean_w);
  assign var_w     = {1'b0, msq_w} - {1'b0, mean_sq_w};
  assign var_clamp = var_w[32] ? 32'd0 : var_w[31:0];

  assign rem_shift = {rem_q, rad_q[47:46]};
  assign trial     = {2'b00, root_q, 2'b01};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && last_sample) state_d = CALC;
      CALC:    state_d = SQRT;
      SQRT:    if (iter_q == 5'd0) state_d = EMIT;
      EMIT:    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    sample_ready = (state_q == ACC) && reset_n;
  end

  always_comb begin
    count_d    = count_q;
    sum_d      = sum_q;
    sumsq_d    = sumsq_q;
    mean_d     = mean_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    iter_d     = iter_q;
    mean_out_d = mean_out_q;
    std_out_d  = std_out_q;
    start_d    = 1'b0;
    case (state_q)
      ACC: begin
        if (accept) begin
          count_d = count_q + WINDOW_LOG2'(1);
          sum_d   = sum_q + SUM_W'(sample_s);
          sumsq_d = sumsq_q + SQ_W'(prod);
        end
      end
      CALC: begin
        mean_d = mean_w;
        rad_d  = {var_clamp, 16'h0000};
        rem_d  = '0;
        root_d = '0;
        iter_d = 5'd23;
      end
      SQRT: begin
        rad_d  = {rad_q[45:0], 2'b00};
        iter_d = iter_q - 5'd1;
        if (rem_shift >= trial) begin
          rem_d  = 26'(rem_shift - trial);
          root_d = {root_q[22:0], 1'b1};
        end else begin
          rem_d  = 26'(rem_shift);
          root_d = {root_q[22:0], 1'b0};
        end
      end
      EMIT: begin
        start_d    = 1'b1;
        mean_out_d = {{8{mean_q[15]}}, mean_q, 8'h00};
        std_out_d  = {8'h00, root_q};
        count_d    = '0;
        sum_d      = '0;
        sumsq_d    = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q    <= '0;
      sum_q      <= '0;
      sumsq_q    <= '0;
      mean_q     <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      iter_q     <= '0;
      mean_out_q <= '0;
      std_out_q  <= '0;
      start_q    <= 1'b0;
    end else begin
      count_q    <= count_d;
      sum_q      <= sum_d;
      sumsq_q    <= sumsq_d;
      mean_q     <= mean_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      iter_q     <= iter_d;
      mean_out_q <= mean_out_d;
      std_out_q  <= std_out_d;
      start_q    <= start_d;
    end
  end

  assign feature_mean = mean_out_q;
  assign feature_std  = std_out_q;
  assign start        = start_q;

endmodule
